fb_write_arbiter: RTL and testbench

Sequences and shares the single write port of the 640x480 8-bit-index framebuffer RAM whose read port feeds the VGA controller. Two requesters compete: the CPU store path (one pixel per handshake) and an internal clear-screen engine that fills the whole frame with one colour index. The block arbitrates between them cycle by cycle and drives the registered RAM write strobe, address and data.

---
 rtl/fb_pkg.sv | 15 +
 rtl/fb_clear_seq.sv | 66 ++++++
 rtl/fb_write_arbiter.sv | 92 +++++++++
 tb/tb_fb_write_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer constants and the clear-engine state encoding.
package fb_pkg;

  localparam int unsigned FB_ADDR_W = 19;
  localparam int unsigned FB_DATA_W = 8;
  localparam int unsigned FB_H_RES  = 640;
  localparam int unsigned FB_V_RES  = 480;
  localparam int unsigned FB_PIXELS = FB_H_RES * FB_V_RES;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/fb_clear_seq.sv
// Full-frame clear engine: walks every pixel address once per clr_start,
// issuing a write each time the arbiter grants it.
module fb_clear_seq
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W = FB_ADDR_W,
  parameter int unsigned DATA_W = FB_DATA_W,
  parameter int unsigned PIXELS = FB_PIXELS
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  input  logic              clr_gnt,
  output logic              clr_req_c,
  output logic [ADDR_W-1:0] clr_addr,
  output logic [DATA_W-1:0] clr_data,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam logic [ADDR_W-1:0] END_CNT = ADDR_W'(PIXELS);

  clr_state_e        state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] color;

  // The counter runs one past the last pixel; that extra cycle keeps busy
  // high through the final write and places clr_done right after it.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state    <= IDLE;
      cnt      <= '0;
      color    <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_start) begin
            state    <= CLEAR;
            cnt      <= '0;
            color    <= clr_color;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt == END_CNT) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else if (clr_gnt) begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign clr_req_c = (state == CLEAR) && (cnt != END_CNT);
  assign clr_addr  = cnt;
  assign clr_data  = color;

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter for the framebuffer write port (CPU stores vs clear engine).
// Build option FB_VBLANK_ONLY_EN restricts grants to vertical blanking.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W = FB_ADDR_W,
  parameter int unsigned DATA_W = FB_DATA_W,
  parameter int unsigned H_RES  = FB_H_RES,
  parameter int unsigned V_RES  = FB_V_RES
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic              iVBLANK,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_ack,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int unsigned PIXELS = H_RES * V_RES;

  logic              vb_ok_c;
  logic              clr_req_c;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_data;
  logic              cpu_elig_c;
  logic              clr_elig_c;
  logic              gnt_cpu_c;
  logic              gnt_clr_c;
  logic              last_cpu;

`ifdef FB_VBLANK_ONLY_EN
  assign vb_ok_c = iVBLANK;
`else
  logic unused_vblank;
  assign unused_vblank = iVBLANK;
  assign vb_ok_c       = 1'b1;
`endif

  fb_clear_seq #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PIXELS (PIXELS)
  ) u_clear_seq (
    .iVGA_CLK  (iVGA_CLK),
    .iRST_n    (iRST_n),
    .clr_start (clr_start),
    .clr_color (clr_color),
    .clr_gnt   (gnt_clr_c),
    .clr_req_c (clr_req_c),
    .clr_addr  (clr_addr),
    .clr_data  (clr_data),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done)
  );

  // A request being acked this cycle is already consumed, hence the ~cpu_ack.
  assign cpu_elig_c = cpu_req & ~cpu_ack & vb_ok_c;
  assign clr_elig_c = clr_req_c & vb_ok_c;
  assign gnt_cpu_c  = cpu_elig_c & (~clr_elig_c | ~last_cpu);
  assign gnt_clr_c  = clr_elig_c & (~cpu_elig_c | last_cpu);

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      cpu_ack  <= 1'b0;
      last_cpu <= 1'b1;
    end else begin
      wr_en   <= gnt_cpu_c | gnt_clr_c;
      cpu_ack <= gnt_cpu_c;
      if (gnt_cpu_c) begin
        wr_addr  <= cpu_addr;
        wr_data  <= cpu_data;
        last_cpu <= 1'b1;
      end else if (gnt_clr_c) begin
        wr_addr  <= clr_addr;
        wr_data  <= clr_data;
        last_cpu <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed self-checking bench for fb_write_arbiter on a reduced 16x8 frame.
module tb_fb_write_arbiter;

  localparam int unsigned AW  = 19;
  localparam int unsigned DW  = 8;
  localparam int unsigned HR  = 16;
  localparam int unsigned VR  = 8;
  localparam int unsigned NPX = HR * VR;

  logic          iVGA_CLK = 1'b0;
  logic          iRST_n;
  logic          iVBLANK;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data;
  logic          cpu_ack;
  logic          clr_start;
  logic [DW-1:0] clr_color;
  logic          clr_busy;
  logic          clr_done;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  int errors = 0;
  int checks = 0;

  fb_write_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .H_RES  (HR),
    .V_RES  (VR)
  ) dut (
    .iVGA_CLK  (iVGA_CLK),
    .iRST_n    (iRST_n),
    .iVBLANK   (iVBLANK),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .cpu_ack   (cpu_ack),
    .clr_start (clr_start),
    .clr_color (clr_color),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;

  task automatic tick();
    @(posedge iVGA_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".wr_en"},    32'(wr_en),    32'd0);
    chk({tag, ".wr_addr"},  32'(wr_addr),  32'd0);
    chk({tag, ".wr_data"},  32'(wr_data),  32'd0);
    chk({tag, ".cpu_ack"},  32'(cpu_ack),  32'd0);
    chk({tag, ".clr_busy"}, 32'(clr_busy), 32'd0);
    chk({tag, ".clr_done"}, 32'(clr_done), 32'd0);
  endtask

  initial begin
    int exp_addr;
    int cpu_n;
    int done_cnt;
    int cyc;
    bit pulse_sent;

    iRST_n    = 1'b0;
    iVBLANK   = 1'b1;
    cpu_req   = 1'b0;
    cpu_addr  = '0;
    cpu_data  = '0;
    clr_start = 1'b0;
    clr_color = '0;
    tick();
    tick();
    chk_idle_outputs("reset");
    iRST_n = 1'b1;
    tick();

    // single CPU store, request held through the ack cycle
    cpu_req  = 1'b1;
    cpu_addr = AW'(32'h00123);
    cpu_data = 8'h5A;
    tick();
    chk("cpu1.wr_en",   32'(wr_en),   32'd1);
    chk("cpu1.wr_addr", 32'(wr_addr), 32'h123);
    chk("cpu1.wr_data", 32'(wr_data), 32'h5A);
    chk("cpu1.ack",     32'(cpu_ack), 32'd1);
    tick();
    chk("cpu1.no_second_wr", 32'(wr_en),   32'd0);
    chk("cpu1.ack_pulse",    32'(cpu_ack), 32'd0);
    chk("cpu1.addr_hold",    32'(wr_addr), 32'h123);
    cpu_req = 1'b0;
    tick();
    chk("cpu1.idle", 32'(wr_en), 32'd0);

    // full clear, no CPU traffic
    clr_color = 8'h07;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    chk("clr.busy_rise", 32'(clr_busy), 32'd1);
    chk("clr.no_wr_yet", 32'(wr_en),    32'd0);
    for (int i = 0; i < int'(NPX); i++) begin
      tick();
      chk("clr.wr_en",   32'(wr_en),    32'd1);
      chk("clr.wr_addr", 32'(wr_addr),  32'(i));
      chk("clr.wr_data", 32'(wr_data),  32'h07);
      chk("clr.busy",    32'(clr_busy), 32'd1);
      chk("clr.done_lo", 32'(clr_done), 32'd0);
    end
    tick();
    chk("clr.done",      32'(clr_done), 32'd1);
    chk("clr.busy_fall", 32'(clr_busy), 32'd0);
    chk("clr.wr_off",    32'(wr_en),    32'd0);
    tick();
    chk("clr.done_once", 32'(clr_done), 32'd0);
    chk("clr.wr_off2",   32'(wr_en),    32'd0);

    // clear interleaved with 10 CPU stores; last grant was the clear, so CPU wins first
    clr_color = 8'h11;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    cpu_req   = 1'b1;
    cpu_addr  = AW'(32'h40000);
    cpu_data  = 8'hC0;
    exp_addr  = 0;
    cpu_n     = 0;
    done_cnt  = 0;
    cyc       = 0;
    while (done_cnt == 0 && cyc < 400) begin
      tick();
      cyc++;
      if (clr_done) done_cnt++;
      if (wr_en) begin
        if (cyc % 2 == 1 && cpu_n < 10) begin
          chk("mix.src_cpu", 32'(cpu_ack), 32'd1);
          chk("mix.cpu_addr", 32'(wr_addr), 32'h40000 + 32'(cpu_n));
          chk("mix.cpu_data", 32'(wr_data), 32'hC0 + 32'(cpu_n));
          cpu_n++;
          if (cpu_n == 10) cpu_req = 1'b0;
          cpu_addr = AW'(32'h40000 + 32'(cpu_n));
          cpu_data = DW'(32'hC0 + 32'(cpu_n));
        end else begin
          chk("mix.src_clr", 32'(cpu_ack), 32'd0);
          chk("mix.clr_addr", 32'(wr_addr), 32'(exp_addr));
          chk("mix.clr_data", 32'(wr_data), 32'h11);
          exp_addr++;
        end
      end
    end
    chk("mix.cpu_writes", 32'(cpu_n),    32'd10);
    chk("mix.clr_writes", 32'(exp_addr), 32'(NPX));
    chk("mix.done_seen",  32'(done_cnt), 32'd1);
    chk("mix.duration",   32'(cyc),      32'(NPX + 10 + 1));

    // clr_start during a clear must be ignored
    clr_color = 8'h07;
    clr_start = 1'b1;
    tick();
    clr_start  = 1'b0;
    exp_addr   = 0;
    done_cnt   = 0;
    pulse_sent = 1'b0;
    for (int c = 0; c < int'(NPX) + 20; c++) begin
      tick();
      clr_start = 1'b0;
      if (clr_done) done_cnt++;
      if (wr_en) begin
        chk("ign.addr", 32'(wr_addr), 32'(exp_addr));
        chk("ign.data", 32'(wr_data), 32'h07);
        exp_addr++;
        if (exp_addr == 40 && !pulse_sent) begin
          clr_color  = 8'h33;
          clr_start  = 1'b1;
          pulse_sent = 1'b1;
        end
      end
    end
    chk("ign.writes",   32'(exp_addr), 32'(NPX));
    chk("ign.done_cnt", 32'(done_cnt), 32'd1);
    chk("ign.idle_end", 32'(clr_busy), 32'd0);

    // simultaneous clr_start and cpu_req: CPU first, clear next edge; out-of-range addr passes
    clr_color = 8'h44;
    clr_start = 1'b1;
    cpu_req   = 1'b1;
    cpu_addr  = AW'(32'h7FFFF);
    cpu_data  = 8'h99;
    tick();
    clr_start = 1'b0;
    cpu_req   = 1'b0;
    chk("sim.cpu_ack",  32'(cpu_ack),  32'd1);
    chk("sim.cpu_addr", 32'(wr_addr),  32'h7FFFF);
    chk("sim.cpu_data", 32'(wr_data),  32'h99);
    chk("sim.busy",     32'(clr_busy), 32'd1);
    tick();
    chk("sim.clr_wr",   32'(wr_en),   32'd1);
    chk("sim.clr_ack",  32'(cpu_ack), 32'd0);
    chk("sim.clr_addr", 32'(wr_addr), 32'd0);
    chk("sim.clr_data", 32'(wr_data), 32'h44);

    // asynchronous reset mid-clear, then a fresh clear from address 0
    cyc = 0;
    while (!(wr_en && wr_addr == AW'(50)) && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("rst.reached_50", 32'(wr_addr), 32'd50);
    iRST_n = 1'b0;
    #1;
    chk_idle_outputs("rst.async");
    tick();
    tick();
    chk("rst.no_done", 32'(clr_done), 32'd0);
    iRST_n = 1'b1;
    tick();
    chk("rst.still_idle", 32'(clr_busy), 32'd0);
    clr_color = 8'h22;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    tick();
    chk("rst.restart_en",   32'(wr_en),   32'd1);
    chk("rst.restart_addr", 32'(wr_addr), 32'd0);
    chk("rst.restart_data", 32'(wr_data), 32'h22);
    tick();
    chk("rst.restart_addr1", 32'(wr_addr), 32'd1);

`ifdef FB_VBLANK_ONLY_EN
    iRST_n = 1'b0;
    tick();
    iRST_n   = 1'b1;
    iVBLANK  = 1'b0;
    cpu_req  = 1'b1;
    cpu_addr = AW'(32'h00200);
    cpu_data = 8'hA5;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("vb.blocked", 32'(wr_en), 32'd0);
    end
    iVBLANK = 1'b1;
    tick();
    chk("vb.wr_en", 32'(wr_en),   32'd1);
    chk("vb.ack",   32'(cpu_ack), 32'd1);
    chk("vb.addr",  32'(wr_addr), 32'h200);
    cpu_req = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
